// File: rtl/display_pkg.sv
// display_pkg: 640x480@60 timing constants and the 16-colour palette shared by the scanout path.
package display_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;
  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'h A00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with undelayed active, sync and frame-tick flags.
module vga_timing
  import display_pkg::*;
#(
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_SYNC_S = V_SYNC_START,
  parameter int V_SYNC_E = V_SYNC_END,
  parameter int V_TOT    = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);
  logic h_end, v_end;
  assign h_end = hcount == 10'(H_TOTAL - 1);
  assign v_end = vcount == 10'(V_TOT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_end ? '0 : hcount + 10'd1;
      if (h_end) vcount <= v_end ? '0 : vcount + 10'd1;
    end
  end
  assign active     = hcount < 10'(H_ACTIVE) && vcount < 10'(V_ACT);
  assign hsync      = !(hcount >= 10'(H_SYNC_START) && hcount < 10'(H_SYNC_END));
  assign vsync      = !(vcount >= 10'(V_SYNC_S) && vcount < 10'(V_SYNC_E));
  assign frame_tick = hcount == '0 && vcount == 10'(V_ACT);
endmodule

// File: rtl/canvas_scanout.sv
// canvas_scanout: composites sprite layers over a 4x-upscaled 160x120 canvas into VGA RGB/sync.
module canvas_scanout
  import display_pkg::*;
#(
  parameter logic [3:0] BG_INDEX = 4'd0,
  parameter int         LAYERS   = 2,
  parameter int         V_ACT    = V_ACTIVE,
  parameter int         V_SYNC_S = V_SYNC_START,
  parameter int         V_SYNC_E = V_SYNC_END,
  parameter int         V_TOT    = V_TOTAL
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [9:0]            x,
  output logic [9:0]            y,
  input  logic [4*LAYERS-1:0]   paletteIndex,
  input  logic [LAYERS-1:0]     valid,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_tick
);
  logic [9:0] hcount, vcount;
  logic active, hs_raw, vs_raw, act_d, hs_d, vs_d;
  logic [3:0] sel;
  logic [11:0] rgb;
  vga_timing #(.V_ACT(V_ACT), .V_SYNC_S(V_SYNC_S), .V_SYNC_E(V_SYNC_E), .V_TOT(V_TOT)) u_timing (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .active(active),
    .hsync(hs_raw), .vsync(vs_raw), .frame_tick(frame_tick)
  );
  assign x = {2'b00, hcount[9:2]};
  assign y = {2'b00, vcount[9:2]};
  // Walk from lowest priority upward so layer 0 wins; invalid layers never touch sel.
  always_comb begin
    sel = BG_INDEX;
    for (int i = LAYERS - 1; i >= 0; i--)
      if (valid[i]) sel = paletteIndex[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_d <= 1'b0;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      act_d <= active;
      hs_d  <= hs_raw;
      vs_d  <= vs_raw;
      rgb   <= act_d ? PALETTE[sel] : 12'h000;
      hsync <= hs_d;
      vsync <= vs_d;
    end
  end
  assign {vga_r, vga_g, vga_b} = rgb;
endmodule

// File: tb/tb_canvas_scanout.sv
// tb_canvas_scanout: scoreboarded per-pixel check of canvas_scanout with a shortened vertical frame.
module tb_canvas_scanout;
  localparam logic [3:0] BG = 4'd9;
  localparam int VA = 12, VSS = 14, VSE = 16, VT = 20;
  localparam int FRAME = 800 * VT;
  logic clk, rst;
  logic [9:0] x, y;
  logic [7:0] paletteIndex;
  logic [1:0] valid;
  logic [3:0] vga_r, vga_g, vga_b;
  logic hsync, vsync, frame_tick;
  canvas_scanout #(.BG_INDEX(BG), .LAYERS(2), .V_ACT(VA), .V_SYNC_S(VSS), .V_SYNC_E(VSE), .V_TOT(VT)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .paletteIndex(paletteIndex), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );
  logic [11:0] pal [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };
  int errors = 0, checks = 0;
  int mh = 0, mv = 0, ph = 0, pv = 0, cyc = 0;
  int hs_run = 0, vs_low = 0, ticks = 0, last_tick = -1, n = 0;
  logic rnd = 1'b0;
  logic [1:0] st_v = 2'b00;
  logic [3:0] st_i0 = 4'd0, st_i1 = 4'd0;
  logic [13:0] q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock: advance the reference raster, compare, then drive the answer for the previous pixel.
  task automatic cycle();
    logic [1:0] v;
    logic [3:0] i0, i1, s;
    logic [13:0] e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      mh = 0; mv = 0; ph = 0; pv = 0; hs_run = 0;
      q.delete();
      check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      check("rst_hsync", hsync, 1'b1);
      check("rst_vsync", vsync, 1'b1);
      check("rst_tick", frame_tick, 1'b0);
    end else begin
      if (mh == 799) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pixel", {vga_r, vga_g, vga_b, hsync, vsync}, e);
      end
      check("xy", {x, y}, {2'b00, 8'(mh >> 2), 2'b00, 8'(mv >> 2)});
      check("tick", frame_tick, mh == 0 && mv == VA);
      if (frame_tick) begin
        ticks++;
        if (last_tick >= 0) check("tick_period", cyc - last_tick, FRAME);
        last_tick = cyc;
      end
      if (!hsync) hs_run++;
      else if (hs_run != 0) begin
        check("hs_width", hs_run, 96);
        hs_run = 0;
      end
      if (!vsync) vs_low++;
      if (rnd) begin
        v = 2'($urandom); i0 = 4'($urandom); i1 = 4'($urandom);
      end else begin
        v = st_v; i0 = st_i0; i1 = st_i1;
      end
      valid = v;
      paletteIndex = {i1, i0};
      s = v[0] ? i0 : v[1] ? i1 : BG;
      q.push_back({(ph < 640 && pv < VA) ? pal[s] : 12'h000,
                   !(ph >= 656 && ph < 752), !(pv >= VSS && pv < VSE)});
      ph = mh; pv = mv;
    end
  endtask

  initial begin
    rst = 1'b1; valid = '0; paletteIndex = '0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle(); cycle();
    check("bg_after_rst", {vga_r, vga_g, vga_b}, 12'h55F);
    st_v = 2'b11; st_i0 = 4'd13; st_i1 = 4'd5;
    cycle(); cycle();
    check("prio_both", {vga_r, vga_g, vga_b}, 12'hF5F);
    st_v = 2'b10;
    cycle(); cycle();
    check("prio_l1", {vga_r, vga_g, vga_b}, 12'hA0A);
    st_v = 2'b00;
    cycle(); cycle();
    check("prio_none", {vga_r, vga_g, vga_b}, 12'h55F);
    rnd = 1'b1; ticks = 0; vs_low = 0;
    repeat (2 * FRAME) cycle();
    check("tick_count", ticks, 2);
    check("vs_low_cycles", vs_low, 2 * 2 * 800);
    n = 0;
    while (!(mh == 700 && mv == 6) && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    check("mid_x", x, 10'd175);
    check("mid_y", y, 10'd1);
    rst = 1'b1;
    repeat (4) cycle();
    rst = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (hsync && n < 1000);
    check("hs_after_rst", n, 658);
    repeat (200) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/canvas_scanout.md
CANVAS_SCANOUT -- requirements
Module: canvas_scanout

Interface
REQ-001 SHALL have parameter BG_INDEX, default 4'd0, palette index shown where no layer is valid.
REQ-002 SHALL have parameter LAYERS, default 2, number of sprite layers composited; layer 0 has highest priority.
REQ-003 SHALL have port clk  input  1  pixel clock (25.175 MHz nominal), one screen pixel per cycle.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port x  output  10  canvas column driven to every sprite module.
REQ-006 SHALL have port y  output  10  canvas row driven to every sprite module.
REQ-007 SHALL have port paletteIndex  input  4*LAYERS  per-layer palette index, layer n in bits [4n+3:4n], returned one cycle after x/y.
REQ-008 SHALL have port valid  input  LAYERS  per-layer opaque flag, aligned with paletteIndex.
REQ-009 SHALL have port vga_r, vga_g, vga_b  output  4 each  pixel colour.
REQ-010 SHALL have port hsync, vsync  output  1 each  active-low sync.
REQ-011 SHALL have port frame_tick  output  1  single-cycle pulse at start of vertical blank.

Function
REQ-012 SHALL keep hcount 0..799 incrementing every cycle, wrapping to 0 after 799, and vcount 0..524 incrementing on each hcount wrap, wrapping to 0 after 524.
REQ-013 SHALL treat hcount<640 and vcount<480 as the active region.
REQ-014 SHALL drive x = {2'b00, hcount[9:2]} and y = {2'b00, vcount[9:2]} combinationally from the counters (4x4 upscale of the 160x120 canvas), in all regions.
REQ-015 SHALL sample paletteIndex/valid one cycle after the x/y they answer (stage 1) and register the RGB output one cycle later (stage 2); total latency counter-to-pin = 2 cycles.
REQ-016 SHALL select the lowest-numbered layer whose valid=1; if none, SHALL use BG_INDEX.
REQ-017 SHALL convert the selected index to 12-bit RGB via a 16-entry constant palette table.
REQ-018 SHALL output RGB 12'h000 whenever the pixel, delayed 2 cycles, lies outside the active region, regardless of valid.
REQ-019 SHALL assert hsync low for hcount 656..751 and vsync low for vcount 490..491, delayed 2 cycles to align with RGB.
REQ-020 SHALL pulse frame_tick for exactly one cycle when hcount=0 and vcount=480, undelayed.
REQ-021 SHALL ignore paletteIndex bits when the matching valid=0; X on those bits SHALL NOT reach the outputs.

Reset
REQ-022 SHALL, while rst=1, set hcount=0, vcount=0, all pipeline stages blank, RGB=12'h000, hsync=1, vsync=1, frame_tick=0.
REQ-023 SHALL, on rst deasserted, output pixel (0,0) colour 2 cycles after the first non-reset edge.
REQ-024 SHALL, on reset asserted mid-frame, restart from (0,0) and produce no partial sync pulse after reset release.

Structure
REQ-025 SHALL take H/V timing constants (640/656/752/800, 480/490/492/525) and the 16x12-bit palette table from shared package display_pkg.
REQ-026 SHALL place the counters, active flag and raw sync/frame_tick in sub-module vga_timing; compositing, palette and delay pipeline stay in canvas_scanout.

Verification
REQ-027 SHALL check reset release: after 2 cycles, RGB is palette[BG_INDEX] with all valid=0; 800*525 cycles later, hcount and vcount have wrapped to 0 exactly once per frame.
REQ-028 SHALL check priority: layer0 valid=1 idx 13, layer1 valid=1 idx 5 -> palette[13]; layer0 valid=0 -> palette[5]; both 0 -> palette[BG_INDEX].
REQ-029 SHALL check scaling: hcount 0..3 -> x=0, hcount 4 -> x=1, hcount 639 -> x=159; vcount 479 -> y=119.
REQ-030 SHALL check blanking and syncs: hcount 640..799 -> RGB 0 even with valid=1; hsync low for 96 cycles starting 2 cycles after hcount=656; vsync low for 2 lines.
REQ-031 SHALL check frame_tick: exactly one pulse per 420000 cycles, at (hcount=0, vcount=480).
REQ-032 SHALL check mid-frame reset at (hcount=700, vcount=300): outputs are the reset values during rst, and the next hsync edge occurs 658 cycles after release.
